// File: rtl/imem_loader.sv
// Loads a length-prefixed little-endian byte stream into instruction memory as
// consecutive 32-bit words, holding the core in reset until the image is committed.
module imem_loader #(
    parameter int ADDR_W    = 16,
    parameter int BASE_ADDR = 0,
    parameter int MAX_WORDS = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       word_count
);

    if ((BASE_ADDR % 4) != 0 || (BASE_ADDR + 4 * MAX_WORDS) > (1 << ADDR_W)) begin : gParamCheck
        $error("imem_loader: BASE_ADDR must be 4-aligned and the image must fit in ADDR_W");
    end

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        FLUSH,
        DONE,
        ERR
    } loaderState_e;

    loaderState_e      state_q, state_d;
    logic [7:0]        lenLo_q, lenLo_d;
    logic [15:0]       len_q, len_d;
    logic [1:0]        byteIdx_q, byteIdx_d;
    logic [15:0]       wordIdx_q, wordIdx_d;
    logic [23:0]       word_q, word_d;
    logic              inReady_q, inReady_d;
    logic              memWe_q, memWe_d;
    logic [ADDR_W-1:0] memAddr_q, memAddr_d;
    logic [31:0]       memWdata_q, memWdata_d;
    logic              coreHold_q, coreHold_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [15:0]       wordCount_q, wordCount_d;
    logic              handshake;
    logic [15:0]       lenIn;

    assign handshake = in_valid && inReady_q;
    assign lenIn     = {in_data, lenLo_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            lenLo_q     <= '0;
            len_q       <= '0;
            byteIdx_q   <= '0;
            wordIdx_q   <= '0;
            word_q      <= '0;
            inReady_q   <= 1'b0;
            memWe_q     <= 1'b0;
            memAddr_q   <= '0;
            memWdata_q  <= '0;
            coreHold_q  <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            wordCount_q <= '0;
        end else begin
            state_q     <= state_d;
            lenLo_q     <= lenLo_d;
            len_q       <= len_d;
            byteIdx_q   <= byteIdx_d;
            wordIdx_q   <= wordIdx_d;
            word_q      <= word_d;
            inReady_q   <= inReady_d;
            memWe_q     <= memWe_d;
            memAddr_q   <= memAddr_d;
            memWdata_q  <= memWdata_d;
            coreHold_q  <= coreHold_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            wordCount_q <= wordCount_d;
        end
    end

    // The write of a completed word is registered here, so it appears one cycle after its 4th byte.
    always_comb begin
        state_d     = state_q;
        lenLo_d     = lenLo_q;
        len_d       = len_q;
        byteIdx_d   = byteIdx_q;
        wordIdx_d   = wordIdx_q;
        word_d      = word_q;
        memWe_d     = 1'b0;
        memAddr_d   = memAddr_q;
        memWdata_d  = memWdata_q;
        wordCount_d = wordCount_q;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d     = LEN_LO;
                    wordCount_d = '0;
                end
            end
            LEN_LO: begin
                if (handshake) begin
                    lenLo_d = in_data;
                    state_d = LEN_HI;
                end
            end
            LEN_HI: begin
                if (handshake) begin
                    len_d     = lenIn;
                    byteIdx_d = '0;
                    wordIdx_d = '0;
                    if (lenIn == 16'd0) begin
                        state_d = DONE;
                    end else if (lenIn > 16'(MAX_WORDS)) begin
                        state_d = ERR;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (handshake) begin
                    byteIdx_d = byteIdx_q + 2'd1;
                    case (byteIdx_q)
                        2'd0: word_d[7:0]   = in_data;
                        2'd1: word_d[15:8]  = in_data;
                        2'd2: word_d[23:16] = in_data;
                        default: begin
                            memWe_d     = 1'b1;
                            memAddr_d   = ADDR_W'(BASE_ADDR) + ADDR_W'({wordIdx_q, 2'b00});
                            memWdata_d  = {in_data, word_q};
                            wordCount_d = wordCount_q + 16'd1;
                            wordIdx_d   = wordIdx_q + 16'd1;
                            if (wordIdx_q == len_q - 16'd1) begin
                                state_d = FLUSH;
                            end
                        end
                    endcase
                end
            end
            FLUSH: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        inReady_d  = (state_d == LEN_LO) || (state_d == LEN_HI) || (state_d == DATA);
        busy_d     = inReady_d || (state_d == FLUSH);
        done_d     = (state_d == DONE);
        error_d    = (state_d == ERR);
        coreHold_d = (state_d != DONE);
    end

    assign in_ready   = inReady_q;
    assign mem_we     = memWe_q;
    assign mem_addr   = memAddr_q;
    assign mem_wdata  = memWdata_q;
    assign core_hold  = coreHold_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign word_count = wordCount_q;

endmodule
